// File: rtl/branch_flag_unit_pkg.sv
// Shared encodings for the branch/flag unit: ALU opcodes, condition codes
// and flag bit positions within the {Z,V,N} flag register.
package branch_flag_unit_pkg;

   localparam logic [3:0] ALU_ADD = 4'b1001;
   localparam logic [3:0] ALU_SUB = 4'b1010;
   localparam logic [3:0] ALU_XOR = 4'b1011;
   localparam logic [3:0] ALU_SLL = 4'b0001;
   localparam logic [3:0] ALU_SRA = 4'b0010;
   localparam logic [3:0] ALU_ROR = 4'b0100;

   localparam logic [2:0] CCC_NE = 3'b000;
   localparam logic [2:0] CCC_EQ = 3'b001;
   localparam logic [2:0] CCC_GT = 3'b010;
   localparam logic [2:0] CCC_LT = 3'b011;
   localparam logic [2:0] CCC_GE = 3'b100;
   localparam logic [2:0] CCC_LE = 3'b101;
   localparam logic [2:0] CCC_OV = 3'b110;
   localparam logic [2:0] CCC_AL = 3'b111;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   // Arithmetic ops update all three flags.
   function automatic logic op_writes_zvn(input logic [3:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

   // Arithmetic, logic and shift ops all update Z.
   function automatic logic op_writes_z(input logic [3:0] op);
      return op_writes_zvn(op) || (op == ALU_XOR) || (op == ALU_SLL) ||
             (op == ALU_SRA) || (op == ALU_ROR);
   endfunction

endpackage

// File: rtl/branch_flag_unit_cond.sv
// Combinational branch condition resolver: effective {Z,V,N} plus a
// condition code produce the taken decision.
module branch_flag_unit_cond
   import branch_flag_unit_pkg::*;
(
   input  logic [2:0] eff,
   input  logic [2:0] ccc,
   output logic       taken
);

   logic z;
   logic v;
   logic n;

   assign z = eff[FLAG_Z];
   assign v = eff[FLAG_V];
   assign n = eff[FLAG_N];

   always_comb begin
      taken = 1'b0;
      unique case (ccc)
         CCC_NE:  taken = !z;
         CCC_EQ:  taken = z;
         CCC_GT:  taken = !z && !n;
         CCC_LT:  taken = n;
         CCC_GE:  taken = z || (!z && !n);
         CCC_LE:  taken = n || z;
         CCC_OV:  taken = v;
         CCC_AL:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_flag_unit.sv
// Flag register, ID-stage branch resolution with same-cycle EX flag bypass,
// registered PC redirect / IF-ID flush and saturating branch counters.
module branch_flag_unit
   import branch_flag_unit_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic [3:0]       ex_alu_op,
   input  logic [2:0]       ex_flags,
   input  logic             stall,
   input  logic             id_branch,
   input  logic             id_branch_reg,
   input  logic [2:0]       id_ccc,
   input  logic [8:0]       id_imm9,
   input  logic [15:0]      id_pc_plus2,
   input  logic [15:0]      id_rs_data,
   output logic [2:0]       flags,
   output logic             redirect,
   output logic [15:0]      redirect_pc,
   output logic             flush_ifid,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              wr_z_p0;
   logic              wr_vn_p0;
   logic [2:0]        eff_p0;
   logic              cond_p0;
   logic              eval_p0;
   logic              take_p0;
   logic signed [15:0] offset_p0;
   logic [15:0]       target_p0;

   // Stage p0: EX flag bypass, condition resolution and target generation.
   assign wr_z_p0  = ex_valid && op_writes_z(ex_alu_op);
   assign wr_vn_p0 = ex_valid && op_writes_zvn(ex_alu_op);

   assign eff_p0[FLAG_Z] = wr_z_p0  ? ex_flags[FLAG_Z] : flags[FLAG_Z];
   assign eff_p0[FLAG_V] = wr_vn_p0 ? ex_flags[FLAG_V] : flags[FLAG_V];
   assign eff_p0[FLAG_N] = wr_vn_p0 ? ex_flags[FLAG_N] : flags[FLAG_N];

   branch_flag_unit_cond u_cond (
      .eff   (eff_p0),
      .ccc   (id_ccc),
      .taken (cond_p0)
   );

   // A branch seen while redirect is high is on the wrong path.
   assign eval_p0   = (id_branch || id_branch_reg) && !stall && !redirect;
   assign take_p0   = eval_p0 && cond_p0;
   assign offset_p0 = signed'({{6{id_imm9[8]}}, id_imm9, 1'b0});
   assign target_p0 = id_branch_reg ? id_rs_data
                                    : id_pc_plus2 + 16'(unsigned'(offset_p0));

   // Stage p1: architectural flags, redirect and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags       <= 3'b000;
         redirect    <= 1'b0;
         flush_ifid  <= 1'b0;
         redirect_pc <= 16'h0000;
         br_count    <= '0;
         taken_count <= '0;
      end else begin
         flags      <= eff_p0;
         redirect   <= take_p0;
         flush_ifid <= take_p0;
         if (take_p0) begin
            redirect_pc <= target_p0;
         end
         if (eval_p0 && (br_count != CNT_MAX)) begin
            br_count <= br_count + 1'b1;
         end
         if (take_p0 && (taken_count != CNT_MAX)) begin
            taken_count <= taken_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed and randomized bench for branch_flag_unit against a behavioural
// model of flags, branch decisions, targets and saturating counters.
module tb_branch_flag_unit;

   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             ex_valid = 1'b0;
   logic [3:0]       ex_alu_op = 4'h0;
   logic [2:0]       ex_flags = 3'b000;
   logic             stall = 1'b0;
   logic             id_branch = 1'b0;
   logic             id_branch_reg = 1'b0;
   logic [2:0]       id_ccc = 3'b000;
   logic [8:0]       id_imm9 = 9'h000;
   logic [15:0]      id_pc_plus2 = 16'h0000;
   logic [15:0]      id_rs_data = 16'h0000;
   logic [2:0]       flags;
   logic             redirect;
   logic [15:0]      redirect_pc;
   logic             flush_ifid;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] taken_count;

   int checks = 0;
   int failures = 0;

   // Reference model state (plain bits and integers).
   bit m_z, m_v, m_n;
   bit m_redirect;
   int m_pc;
   int m_br, m_tk;

   branch_flag_unit #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .ex_alu_op     (ex_alu_op),
      .ex_flags      (ex_flags),
      .stall         (stall),
      .id_branch     (id_branch),
      .id_branch_reg (id_branch_reg),
      .id_ccc        (id_ccc),
      .id_imm9       (id_imm9),
      .id_pc_plus2   (id_pc_plus2),
      .id_rs_data    (id_rs_data),
      .flags         (flags),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .flush_ifid    (flush_ifid),
      .br_count      (br_count),
      .taken_count   (taken_count)
   );

   always #5 clk = ~clk;

   function automatic bit cond_ref(input int c, input bit z, input bit v, input bit n);
      case (c)
         0: return !z;
         1: return z;
         2: return !z && !n;
         3: return n;
         4: return z || (!z && !n);
         5: return n || z;
         6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_edge();
      int op;
      bit ez, ev, en, eval, tk;
      int imm_s;
      op = int'(ex_alu_op);
      ez = m_z; ev = m_v; en = m_n;
      if (ex_valid && (op == 9 || op == 10)) begin
         ez = ex_flags[2]; ev = ex_flags[1]; en = ex_flags[0];
      end else if (ex_valid && (op == 11 || op == 1 || op == 2 || op == 4)) begin
         ez = ex_flags[2];
      end
      eval = (id_branch || id_branch_reg) && !stall && !m_redirect;
      tk = eval && cond_ref(int'(id_ccc), ez, ev, en);
      imm_s = (int'(id_imm9) >= 256) ? int'(id_imm9) - 512 : int'(id_imm9);
      if (rst) begin
         m_z = 0; m_v = 0; m_n = 0;
         m_redirect = 0; m_pc = 0; m_br = 0; m_tk = 0;
      end else begin
         m_z = ez; m_v = ev; m_n = en;
         m_redirect = tk;
         if (tk) begin
            if (id_branch_reg) m_pc = int'(id_rs_data);
            else m_pc = (int'(id_pc_plus2) + 2 * imm_s + 65536) % 65536;
         end
         if (eval && m_br < CNT_MAX) m_br++;
         if (tk && m_tk < CNT_MAX) m_tk++;
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [3:0] op, input logic [2:0] fl,
                       input bit st, input bit b, input bit br, input logic [2:0] c,
                       input logic [8:0] imm, input logic [15:0] pc, input logic [15:0] rs);
      rst = r; ex_valid = v; ex_alu_op = op; ex_flags = fl; stall = st;
      id_branch = b; id_branch_reg = br; id_ccc = c; id_imm9 = imm;
      id_pc_plus2 = pc; id_rs_data = rs;
      @(posedge clk);
      model_edge();
      #1;
      chk("flags", 32'(flags), 32'({m_z, m_v, m_n}));
      chk("redirect", 32'(redirect), 32'(m_redirect));
      chk("flush_ifid", 32'(flush_ifid), 32'(m_redirect));
      chk("redirect_pc", 32'(redirect_pc), 32'(m_pc));
      chk("br_count", 32'(br_count), 32'(m_br));
      chk("taken_count", 32'(taken_count), 32'(m_tk));
   endtask

   task automatic idle();
      step(0, 0, 4'h0, 3'b000, 0, 0, 0, 3'b000, 9'h000, 16'h0000, 16'h0000);
   endtask

   initial begin
      m_z = 0; m_v = 0; m_n = 0; m_redirect = 0; m_pc = 0; m_br = 0; m_tk = 0;
      #2;
      // Reset beats a flag write and a branch in the same cycle.
      step(1, 1, 4'b1001, 3'b111, 0, 1, 0, 3'b111, 9'h004, 16'h0100, 16'h0000);
      chk("rst_flags", 32'(flags), 32'h0);
      chk("rst_br", 32'(br_count), 32'h0);

      // Flag write masks.
      step(0, 1, 4'b1001, 3'b100, 0, 0, 0, 3'b000, 9'h0, 16'h0, 16'h0);
      chk("add_flags", 32'(flags), 32'h4);
      step(0, 1, 4'b1011, 3'b000, 0, 0, 0, 3'b000, 9'h0, 16'h0, 16'h0);
      chk("xor_flags", 32'(flags), 32'h0);
      step(0, 1, 4'b1010, 3'b011, 0, 0, 0, 3'b000, 9'h0, 16'h0, 16'h0);
      step(0, 1, 4'b0001, 3'b100, 0, 0, 0, 3'b000, 9'h0, 16'h0, 16'h0);
      chk("sll_flags", 32'(flags), 32'h7);
      step(0, 0, 4'b1001, 3'b000, 0, 0, 0, 3'b000, 9'h0, 16'h0, 16'h0);
      chk("novalid_flags", 32'(flags), 32'h7);
      step(0, 1, 4'b1111, 3'b000, 0, 0, 0, 3'b000, 9'h0, 16'h0, 16'h0);
      chk("otherop_flags", 32'(flags), 32'h7);

      // Bypass: flags 000, SUB produces Z in the branch cycle.
      step(0, 1, 4'b1001, 3'b000, 0, 0, 0, 3'b000, 9'h0, 16'h0, 16'h0);
      step(0, 1, 4'b1010, 3'b100, 0, 1, 0, 3'b001, 9'h1FF, 16'h0010, 16'h0);
      chk("bypass_redirect", 32'(redirect), 32'h1);
      chk("bypass_pc", 32'(redirect_pc), 32'h000E);
      idle();
      chk("redirect_drop", 32'(redirect), 32'h0);
      chk("pc_hold", 32'(redirect_pc), 32'h000E);

      // Target wrap and register target.
      step(0, 0, 4'h0, 3'b000, 0, 1, 0, 3'b111, 9'h002, 16'hFFFE, 16'h0);
      chk("wrap_pc", 32'(redirect_pc), 32'h0002);
      idle();
      step(0, 0, 4'h0, 3'b000, 0, 0, 1, 3'b111, 9'h0AA, 16'h5555, 16'h1234);
      chk("br_pc", 32'(redirect_pc), 32'h1234);
      idle();

      // Wrong-path branch and stall.
      step(1, 0, 4'h0, 3'b000, 0, 0, 0, 3'b000, 9'h0, 16'h0, 16'h0);
      step(0, 0, 4'h0, 3'b000, 0, 1, 0, 3'b111, 9'h010, 16'h0200, 16'h0);
      step(0, 0, 4'h0, 3'b000, 0, 1, 0, 3'b111, 9'h020, 16'h0400, 16'h0);
      chk("wrongpath_redirect", 32'(redirect), 32'h0);
      chk("wrongpath_br", 32'(br_count), 32'h1);
      chk("wrongpath_tk", 32'(taken_count), 32'h1);
      for (int i = 0; i < 3; i++)
         step(0, 0, 4'h0, 3'b000, 1, 1, 0, 3'b111, 9'h030, 16'h0600, 16'h0);
      chk("stall_br", 32'(br_count), 32'h1);
      chk("stall_redirect", 32'(redirect), 32'h0);

      // Saturation: OV with V=0 never taken, so every cycle evaluates.
      for (int i = 0; i < CNT_MAX + 4; i++)
         step(0, 0, 4'h0, 3'b000, 0, 1, 0, 3'b110, 9'h0, 16'h0, 16'h0);
      chk("sat_br", 32'(br_count), 32'(CNT_MAX));

      // Sweep every condition code against every flag value via bypass.
      step(1, 0, 4'h0, 3'b000, 0, 0, 0, 3'b000, 9'h0, 16'h0, 16'h0);
      for (int f = 0; f < 8; f++) begin
         for (int c = 0; c < 8; c++) begin
            step(0, 1, 4'b1001, 3'(f), 0, 1, 0, 3'(c), 9'(f * 8 + c), 16'h1000, 16'h0);
            idle();
         end
      end

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] op;
         int kind;
         case ($urandom_range(0, 7))
            0: op = 4'b1001; 1: op = 4'b1010; 2: op = 4'b1011; 3: op = 4'b0001;
            4: op = 4'b0010; 5: op = 4'b0100;
            default: op = 4'($urandom_range(0, 15));
         endcase
         kind = $urandom_range(0, 2);
         step(($urandom_range(0, 39) == 0), 1'($urandom), op, 3'($urandom),
              ($urandom_range(0, 4) == 0), (kind == 1), (kind == 2), 3'($urandom),
              9'($urandom), 16'($urandom), 16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
